wave_meter: RTL
===============

// Module: wave_meter
// PURPOSE
//  Receive-side companion to the waveform generator: consumes 8-bit samples from the
//  ADC capture path and measures the incoming periodic waveform. Detects rising
//  crossings of a programmable level (with hysteresis), counts samples per period, and
//  tracks min/max/peak-to-peak per period. Results feed the status display and the
//  loopback self-test (generator DAC -> ADC -> this block).
// PARAMETERS
//  DW    8   sample width (bits)
//  CW    16  period counter width; also sets the no-signal timeout (2^CW-1 samples)
//  HYST  4   hysteresis below level required to re-arm the crossing detector
// PORTS
//  clk         in   1    system clock
//  rst_n       in   1    asynchronous reset, active-low
//  smp_valid   in   1    sample strobe; smp_data accepted on clk edge when high
//  smp_data    in   DW   unsigned ADC sample
//  level       in   DW   trigger level; sampled with each accepted sample
//  meas_valid  out  1    one-cycle pulse: period/vmax/vmin/vpp updated
//  period      out  CW   accepted samples per waveform period
//  vmax        out  DW   maximum sample in last measured period
//  vmin        out  DW   minimum sample in last measured period
//  vpp         out  DW   vmax - vmin
//  no_signal   out  1    sticky: timeout with no crossing; cleared by next meas_valid
// BEHAVIOUR
//  - Reset (async): all outputs 0, state SEEK, armed=0, counters 0. Reset mid-period
//    discards the partial window; no meas_valid is emitted for it.
//  - smp_valid low: state, counters, min/max trackers and armed hold; nothing changes.
//  - Arm threshold thr = (level >= HYST) ? level-HYST : 0 (saturating, no wrap).
//    Accepted sample <= thr sets armed. Crossing = armed && sample >= level; a crossing
//    clears armed in the same cycle (one crossing per arm).
//  - Window = accepted samples from a crossing sample (inclusive) to the next crossing
//    sample (exclusive). The ending crossing sample opens the next window.
//  - States:
//    SEEK: wait for crossing. On crossing -> MEAS; cnt<=1; max<=min<=sample.
//    MEAS: each non-crossing accepted sample: cnt+=1, update max/min.
//      On crossing: period<=cnt, vmax<=max, vmin<=min, vpp<=max-min, meas_valid=1,
//      no_signal<=0; restart window with this sample (cnt<=1, max<=min<=sample); stay MEAS.
//      If cnt == 2^CW-1 and accepted sample is not a crossing: no_signal<=1, -> SEEK,
//      armed<=0; period/vmax/vmin/vpp hold last values; no meas_valid.
//  - Latency: meas_valid asserts in the cycle after the clk edge accepting the crossing
//    sample (registered outputs), high exactly one cycle; results stable until next.
//  - Crossing and timeout on same sample: crossing wins.
//  - level changes take effect on the next accepted sample; armed is not cleared.
//  - vpp is unsigned DW-bit; vmax >= vmin always holds, no underflow.
//  - First crossing after reset/SEEK never produces meas_valid (needs two crossings).
// TESTING
//  1 Sawtooth 0..255 repeating, smp_valid=1 every clk, level=128 -> from 2nd crossing
//    meas_valid every 256 clks; period=256, vmax=255, vmin=0, vpp=255, no_signal=0.
//  2 Square 8x0x00 / 8x0xFF, level=128 -> period=16, vmax=255, vmin=0, vpp=255.
//  3 Sawtooth of test 1 with smp_valid high 1 clk in 3 -> period=256 (samples, not
//    clks), meas_valid spacing 768 clks; values identical to test 1.
//  4 CW=8 instance, lock on sawtooth then hold smp_data=200 -> after 255 accepted
//    samples in window no_signal=1, outputs hold 256-derived values... (CW=8: use
//    0..99 ramp, period=100 first); resume ramp -> no_signal clears on next meas_valid.
//  5 level=2 (< HYST), triangle 0..255..0 period 510 -> arms only at 0; period=510.
//  6 Assert rst_n low mid-window for 3 clks -> all outputs 0 immediately (async);
//    first meas_valid only after two new crossings.

Source files
------------

// File: rtl/wave_meter.sv
// rtl/wave_meter.sv - periodic waveform meter: hysteretic level crossing, period and min/max/p-p per period
// Windows run from one rising crossing (inclusive) to the next; a full counter without a crossing reports no_signal.
module wave_meter #(
   parameter int DW   = 8,
   parameter int CW   = 16,
   parameter int HYST = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          smp_valid,
   input  logic [DW-1:0] smp_data,
   input  logic [DW-1:0] level,
   output logic          meas_valid,
   output logic [CW-1:0] period,
   output logic [DW-1:0] vmax,
   output logic [DW-1:0] vmin,
   output logic [DW-1:0] vpp,
   output logic          no_signal
);

   typedef enum logic {SEEK, MEAS} state_t;

   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [DW-1:0] HYST_V  = DW'(HYST);

   state_t        state;
   logic          armed;
   logic [CW-1:0] cnt;
   logic [DW-1:0] cur_max;
   logic [DW-1:0] cur_min;

   logic [DW-1:0] thr;
   logic          crossing;
   logic          timeout;

   // Threshold saturates at zero so small levels never wrap to a huge arm point.
   always_comb begin
      thr      = (level >= HYST_V) ? (level - HYST_V) : '0;
      crossing = armed && (smp_data >= level);
      timeout  = (state == MEAS) && !crossing && (cnt == CNT_MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= SEEK;
         armed      <= 1'b0;
         cnt        <= '0;
         cur_max    <= '0;
         cur_min    <= '0;
         meas_valid <= 1'b0;
         period     <= '0;
         vmax       <= '0;
         vmin       <= '0;
         vpp        <= '0;
         no_signal  <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         if (smp_valid) begin
            if (crossing || timeout) begin
               armed <= 1'b0;
            end else if (smp_data <= thr) begin
               armed <= 1'b1;
            end

            if (crossing) begin
               // The crossing sample closes the old window and opens the next one.
               if (state == MEAS) begin
                  period     <= cnt;
                  vmax       <= cur_max;
                  vmin       <= cur_min;
                  vpp        <= cur_max - cur_min;
                  meas_valid <= 1'b1;
                  no_signal  <= 1'b0;
               end
               state   <= MEAS;
               cnt     <= CW'(1);
               cur_max <= smp_data;
               cur_min <= smp_data;
            end else if (timeout) begin
               no_signal <= 1'b1;
               state     <= SEEK;
            end else if (state == MEAS) begin
               cnt <= cnt + CW'(1);
               if (smp_data > cur_max) cur_max <= smp_data;
               if (smp_data < cur_min) cur_min <= smp_data;
            end
         end
      end
   end

endmodule
